fu_pipe: RTL and testbench

- Parametrised successor of the PE functional unit in the PEA.
- Adds a valid/ready handshake with back-pressure on both sides and a multicycle radix-2 divider controlled by an FSM.
- Adds a configurable-latency multiplier and a length-counted accumulate mode.
- Sits inside each PE between the operand muxes and the PE output register; opcode type is pea_pkg::fu_instr_t.

---
 rtl/fu_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_fu_pipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fu_pipe.sv
// Pipelined PE functional unit: 1-cycle ALU ops, multi-cycle multiply, radix-2 restoring
// divider and length-counted accumulation behind a valid/ready handshake on both sides.
package pea_pkg;
   typedef enum logic [3:0] {
      FU_ADD    = 4'd0,
      FU_SUB    = 4'd1,
      FU_LSH    = 4'd2,
      FU_LRSH   = 4'd3,
      FU_ARSH   = 4'd4,
      FU_MAX    = 4'd5,
      FU_MIN    = 4'd6,
      FU_ABS    = 4'd7,
      FU_SGNMUL = 4'd8,
      FU_MUL    = 4'd9,
      FU_DIV    = 4'd10,
      FU_DIVU   = 4'd11,
      FU_ACC    = 4'd12
   } fu_instr_t;
endpackage

module fu_pipe
   import pea_pkg::*;
#(
   parameter int N_BITS    = 32,
   parameter int MUL_LAT   = 2,
   parameter int ACC_LEN_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [N_BITS-1:0]    a_i,
   input  logic [N_BITS-1:0]    b_i,
   input  fu_instr_t            instr_i,
   input  logic [ACC_LEN_W-1:0] acc_len_i,
   input  logic                 valid_a_i,
   input  logic                 valid_b_i,
   output logic                 ready_o,
   input  logic                 flush_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [N_BITS-1:0]    res_o
);

   localparam int SH_W  = $clog2(N_BITS);
   localparam int MCW   = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
   localparam int DCW   = $clog2(N_BITS + 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t                r_state;
   logic [N_BITS-1:0]     r_res;
   logic [MCW-1:0]        r_mul_cnt;
   logic [DCW-1:0]        r_div_cnt;
   logic [N_BITS-1:0]     r_acc;
   logic [ACC_LEN_W-1:0]  r_acc_cnt;
   logic [ACC_LEN_W-1:0]  r_acc_len;

   logic [N_BITS-1:0]     r_mul_res;
   logic [N_BITS-1:0]     r_quo;
   logic [N_BITS-1:0]     r_rem;
   logic [N_BITS-1:0]     r_dvs;
   logic                  r_neg;
   logic                  r_dz;

   logic                  w_accept;
   logic                  w_is_div;
   logic [SH_W-1:0]       w_shamt;
   logic [N_BITS-1:0]     w_alu;
   logic [N_BITS-1:0]     w_prod;
   logic [N_BITS:0]       w_shift;
   logic                  w_ge;
   logic [N_BITS-1:0]     w_rem_nxt;
   logic [N_BITS-1:0]     w_quo_nxt;
   logic [N_BITS-1:0]     w_div_res;
   logic [ACC_LEN_W-1:0]  w_acc_len_in;
   logic [ACC_LEN_W-1:0]  w_acc_len;
   logic [ACC_LEN_W-1:0]  w_acc_cnt_nxt;
   logic                  w_acc_last;
   logic [N_BITS-1:0]     w_acc_sum;

   assign ready_o  = (r_state == S_IDLE) | ((r_state == S_DONE) & ready_i);
   assign valid_o  = (r_state == S_DONE);
   assign res_o    = r_res;
   assign w_accept = valid_a_i & valid_b_i & ready_o;
   assign w_is_div = (instr_i == FU_DIV);
   assign w_shamt  = b_i[SH_W-1:0];
   assign w_prod   = a_i * b_i;

   // NOTE: always_comb assigns a default first so no path leaves w_alu unassigned (no latch).
   always_comb begin
      w_alu = '0;
      case (instr_i)
         FU_ADD:    w_alu = a_i + b_i;
         FU_SUB:    w_alu = a_i - b_i;
         FU_LSH:    w_alu = a_i << w_shamt;
         FU_LRSH:   w_alu = a_i >> w_shamt;
         FU_ARSH:   w_alu = $unsigned($signed(a_i) >>> w_shamt);
         FU_MAX:    w_alu = (a_i > b_i) ? a_i : b_i;
         FU_MIN:    w_alu = (a_i < b_i) ? a_i : b_i;
         FU_ABS:    w_alu = a_i[N_BITS-1] ? -a_i : a_i;
         FU_SGNMUL: w_alu = a_i[N_BITS-1] ? -b_i : b_i;
         default:   w_alu = '0;
      endcase
   end

   // One restoring step: shift in the next dividend bit, subtract when the divisor fits.
   assign w_shift   = {r_rem, r_quo[N_BITS-1]};
   assign w_ge      = (w_shift >= {1'b0, r_dvs});
   assign w_rem_nxt = w_ge ? (w_shift[N_BITS-1:0] - r_dvs) : w_shift[N_BITS-1:0];
   assign w_quo_nxt = {r_quo[N_BITS-2:0], w_ge};
   assign w_div_res = r_dz ? '1 : (r_neg ? -w_quo_nxt : w_quo_nxt);

   // A zero length counts as one; the length is latched only on the first accept of a burst.
   assign w_acc_len_in  = (acc_len_i == '0) ? ACC_LEN_W'(1) : acc_len_i;
   assign w_acc_len     = (r_acc_cnt == '0) ? w_acc_len_in : r_acc_len;
   assign w_acc_cnt_nxt = r_acc_cnt + ACC_LEN_W'(1);
   assign w_acc_last    = (w_acc_cnt_nxt == w_acc_len);
   assign w_acc_sum     = r_acc + a_i;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state   <= S_IDLE;
         r_res     <= '0;
         r_mul_cnt <= '0;
         r_div_cnt <= '0;
         r_acc     <= '0;
         r_acc_cnt <= '0;
         r_acc_len <= '0;
      end else if (flush_i) begin
         r_state   <= S_IDLE;
         r_acc     <= '0;
         r_acc_cnt <= '0;
      end else begin
         case (r_state)
            S_MUL: begin
               if (r_mul_cnt == MCW'(1)) begin
                  r_state <= S_DONE;
                  r_res   <= r_mul_res;
               end else begin
                  r_mul_cnt <= r_mul_cnt - MCW'(1);
               end
            end
            S_DIV: begin
               if (r_div_cnt == DCW'(1)) begin
                  r_state <= S_DONE;
                  r_res   <= w_div_res;
               end
               r_div_cnt <= r_div_cnt - DCW'(1);
            end
            S_DONE: begin
               if (ready_i) r_state <= S_IDLE;
            end
            default: ;
         endcase

         // A new accept (from IDLE, or back-to-back from DONE) overrides the moves above.
         if (w_accept) begin
            if (instr_i == FU_ACC) begin
               if (w_acc_last) begin
                  r_state   <= S_DONE;
                  r_res     <= w_acc_sum;
                  r_acc     <= '0;
                  r_acc_cnt <= '0;
               end else begin
                  r_state   <= S_IDLE;
                  r_acc     <= w_acc_sum;
                  r_acc_cnt <= w_acc_cnt_nxt;
                  r_acc_len <= w_acc_len;
               end
            end else begin
               r_acc     <= '0;
               r_acc_cnt <= '0;
               case (instr_i)
                  FU_MUL: begin
                     if (MUL_LAT == 1) begin
                        r_state <= S_DONE;
                        r_res   <= w_prod;
                     end else begin
                        r_state   <= S_MUL;
                        r_mul_cnt <= MCW'(MUL_LAT - 1);
                     end
                  end
                  FU_DIV, FU_DIVU: begin
                     r_state   <= S_DIV;
                     r_div_cnt <= DCW'(N_BITS);
                  end
                  default: begin
                     r_state <= S_DONE;
                     r_res   <= w_alu;
                  end
               endcase
            end
         end
      end
   end

   // NOTE: pure datapath registers carry no reset; control state decides when they are meaningful.
   always_ff @(posedge clk_i) begin
      if (w_accept) begin
         r_mul_res <= w_prod;
         r_quo     <= (w_is_div && a_i[N_BITS-1]) ? -a_i : a_i;
         r_dvs     <= (w_is_div && b_i[N_BITS-1]) ? -b_i : b_i;
         r_rem     <= '0;
         r_neg     <= w_is_div & (a_i[N_BITS-1] ^ b_i[N_BITS-1]);
         r_dz      <= (b_i == '0);
      end else if (r_state == S_DIV) begin
         r_quo <= w_quo_nxt;
         r_rem <= w_rem_nxt;
      end
   end

endmodule

// File: tb/tb_fu_pipe.sv
// Self-checking bench for fu_pipe: vector table, hand-written handshake/flush/ACC sequences
// and randomized ops compared against an arithmetic reference model.
module tb_fu_pipe;
   import pea_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n_i;
   logic [31:0] a_i, b_i;
   fu_instr_t   instr_i;
   logic [7:0]  acc_len_i;
   logic        valid_a_i, valid_b_i, flush_i, ready_i;
   logic        ready_o, valid_o;
   logic [31:0] res_o;
   logic        ready1, valid1;
   logic [31:0] res1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fu_pipe #(.N_BITS(32), .MUL_LAT(2), .ACC_LEN_W(8)) dut (
      .clk_i(clk), .rst_n_i(rst_n_i), .a_i(a_i), .b_i(b_i), .instr_i(instr_i),
      .acc_len_i(acc_len_i), .valid_a_i(valid_a_i), .valid_b_i(valid_b_i),
      .ready_o(ready_o), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
      .res_o(res_o)
   );

   fu_pipe #(.N_BITS(32), .MUL_LAT(1), .ACC_LEN_W(8)) dut1 (
      .clk_i(clk), .rst_n_i(rst_n_i), .a_i(a_i), .b_i(b_i), .instr_i(instr_i),
      .acc_len_i(acc_len_i), .valid_a_i(valid_a_i), .valid_b_i(valid_b_i),
      .ready_o(ready1), .flush_i(flush_i), .valid_o(valid1), .ready_i(ready_i),
      .res_o(res1)
   );

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
      string       name;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference model: plain arithmetic on the operation's definition.
   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint p;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a << b[4:0];
         4'd3:  return a >> b[4:0];
         4'd4:  return $unsigned($signed(a) >>> b[4:0]);
         4'd5:  return (a > b) ? a : b;
         4'd6:  return (a < b) ? a : b;
         4'd7:  return ($signed(a) < 0) ? 32'(-$signed(a)) : a;
         4'd8:  return ($signed(a) < 0) ? 32'(-$signed(b)) : b;
         4'd9: begin
            p = longint'($signed(a)) * longint'($signed(b));
            return p[31:0];
         end
         4'd10: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $unsigned($signed(a) / $signed(b));
         end
         4'd11: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         default: return 32'h0;
      endcase
   endfunction

   function automatic int model_lat(input logic [3:0] op);
      if (op == 4'd9) return 2;
      if (op == 4'd10 || op == 4'd11) return 33;
      return 1;
   endfunction

   task automatic idle_inputs();
      valid_a_i = 1'b0;
      valid_b_i = 1'b0;
      flush_i   = 1'b0;
   endtask

   // Issue one op with ready_i=1, measure latency to valid_o, check result and busy ready_o.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
      int n;
      bit busy_bad;
      @(negedge clk);
      instr_i = fu_instr_t'(op);
      a_i = a;
      b_i = b;
      valid_a_i = 1'b1;
      valid_b_i = 1'b1;
      ready_i = 1'b1;
      #1;
      n = 0;
      while (!ready_o && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!ready_o) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: ready_o never rose", nm);
      end
      @(negedge clk);
      valid_a_i = 1'b0;
      valid_b_i = 1'b0;
      n = 1;
      busy_bad = 1'b0;
      while (!valid_o && n < 200) begin
         if (ready_o) busy_bad = 1'b1;
         @(negedge clk);
         n++;
      end
      check({nm, " latency"}, 32'(n), 32'(lat));
      check({nm, " result"}, res_o, exp);
      if (lat > 1) check({nm, " busy ready_o"}, {31'b0, busy_bad}, 32'd0);
   endtask

   // Consecutive ACC accepts of base, base+1, ...; acc_len_i is scrambled after the first.
   task automatic acc_burst(input logic [7:0] len, input int cnt, input logic [31:0] base,
                            input string nm);
      logic [31:0] sum;
      sum = 0;
      for (int k = 0; k < cnt; k++) begin
         @(negedge clk);
         if (k > 0) check({nm, " no early valid"}, {31'b0, valid_o}, 32'd0);
         instr_i   = FU_ACC;
         a_i       = base + 32'(k);
         b_i       = $urandom;
         acc_len_i = (k == 0) ? len : 8'd1;
         valid_a_i = 1'b1;
         valid_b_i = 1'b1;
         ready_i   = 1'b1;
         sum += base + 32'(k);
      end
      @(negedge clk);
      valid_a_i = 1'b0;
      valid_b_i = 1'b0;
      check({nm, " valid"}, {31'b0, valid_o}, 32'd1);
      check({nm, " sum"}, res_o, sum);
      @(negedge clk);
      check({nm, " single result"}, {31'b0, valid_o}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      logic [31:0] pick[6];
      logic [3:0] rop;
      logic [31:0] ra, rb;

      vecs[0]  = '{4'd0,  32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1,  "ADD ovf"};
      vecs[1]  = '{4'd1,  32'h5,         32'h9,         32'hFFFF_FFFC, 1,  "SUB"};
      vecs[2]  = '{4'd2,  32'h1,         32'h25,        32'h20,        1,  "LSH shamt"};
      vecs[3]  = '{4'd3,  32'h8000_0000, 32'h4,         32'h0800_0000, 1,  "LRSH"};
      vecs[4]  = '{4'd4,  32'h8000_0000, 32'h4,         32'hF800_0000, 1,  "ARSH neg"};
      vecs[5]  = '{4'd4,  32'h7FFF_FFF0, 32'h4,         32'h07FF_FFFF, 1,  "ARSH pos"};
      vecs[6]  = '{4'd5,  32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFF, 1,  "MAX unsigned"};
      vecs[7]  = '{4'd6,  32'hFFFF_FFFF, 32'h1,         32'h1,         1,  "MIN unsigned"};
      vecs[8]  = '{4'd7,  32'h8000_0000, 32'h3,         32'h8000_0000, 1,  "ABS minint"};
      vecs[9]  = '{4'd7,  32'hFFFF_FFFB, 32'h3,         32'h5,         1,  "ABS neg"};
      vecs[10] = '{4'd8,  32'hFFFF_FFFF, 32'h7,         32'hFFFF_FFF9, 1,  "SGNMUL neg"};
      vecs[11] = '{4'd8,  32'h1,         32'h7,         32'h7,         1,  "SGNMUL pos"};
      vecs[12] = '{4'd15, 32'h3,         32'h4,         32'h0,         1,  "undefined op"};
      vecs[13] = '{4'd9,  32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFF1, 2,  "MUL"};
      vecs[14] = '{4'd10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33, "DIV -7/2"};
      vecs[15] = '{4'd11, 32'h7,         32'h0,         32'hFFFF_FFFF, 33, "DIVU by 0"};
      vecs[16] = '{4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, "DIV minint/-1"};
      vecs[17] = '{4'd10, 32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "DIV 7/-2"};
      vecs[18] = '{4'd11, 32'd100,       32'd7,         32'd14,        33, "DIVU 100/7"};
      vecs[19] = '{4'd10, 32'hFFFF_FFF8, 32'h0,         32'hFFFF_FFFF, 33, "DIV by 0"};

      rst_n_i = 1'b0;
      idle_inputs();
      ready_i = 1'b1;
      instr_i = FU_ADD;
      a_i = 0;
      b_i = 0;
      acc_len_i = 0;
      repeat (3) @(negedge clk);
      check("reset valid_o", {31'b0, valid_o}, 32'd0);
      check("reset res_o", res_o, 32'd0);
      check("reset ready_o", {31'b0, ready_o}, 32'd1);
      rst_n_i = 1'b1;

      for (int i = 0; i < 20; i++)
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

      // Back-to-back ADDs: one result per cycle, ready_o held high.
      @(negedge clk);
      instr_i = FU_ADD;
      valid_a_i = 1'b1;
      valid_b_i = 1'b1;
      ready_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a_i = 32'h7FFF_FFFF + 32'(k);
         b_i = 32'h1;
         #1;
         check("b2b ready_o", {31'b0, ready_o}, 32'd1);
         @(negedge clk);
         check("b2b valid_o", {31'b0, valid_o}, 32'd1);
         check("b2b res_o", res_o, 32'h8000_0000 + 32'(k));
      end
      valid_a_i = 1'b0;
      valid_b_i = 1'b0;
      @(negedge clk);
      check("b2b drain", {31'b0, valid_o}, 32'd0);

      acc_burst(8'd4, 4, 32'd1, "ACC 1..4");
      acc_burst(8'd4, 4, 32'd5, "ACC 5..8");
      acc_burst(8'd0, 1, 32'd9, "ACC len0");

      // ACC burst interrupted by ADD, then a fresh burst must start from zero.
      acc_burst(8'd1, 1, 32'd0, "ACC resync");
      @(negedge clk);
      instr_i = FU_ACC;
      a_i = 32'd100;
      acc_len_i = 8'd4;
      valid_a_i = 1'b1;
      valid_b_i = 1'b1;
      @(negedge clk);
      valid_a_i = 1'b0;
      valid_b_i = 1'b0;
      do_op(4'd0, 32'd1, 32'd2, 32'd3, 1, "ADD mid-burst");
      acc_burst(8'd2, 2, 32'd1, "ACC after discard");

      // Back-pressure: result held while ready_i=0, nothing new accepted.
      @(negedge clk);
      instr_i = FU_ADD;
      a_i = 32'd3;
      b_i = 32'd4;
      valid_a_i = 1'b1;
      valid_b_i = 1'b1;
      ready_i = 1'b0;
      @(negedge clk);
      instr_i = FU_SUB;
      a_i = 32'd20;
      b_i = 32'd3;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp ready_o", {31'b0, ready_o}, 32'd0);
         check("bp valid_o", {31'b0, valid_o}, 32'd1);
         check("bp res_o", res_o, 32'd7);
         @(negedge clk);
      end
      ready_i = 1'b1;
      #1;
      check("bp release ready_o", {31'b0, ready_o}, 32'd1);
      @(negedge clk);
      valid_a_i = 1'b0;
      valid_b_i = 1'b0;
      check("bp new valid", {31'b0, valid_o}, 32'd1);
      check("bp new res", res_o, 32'd17);
      @(negedge clk);
      check("bp single result", {31'b0, valid_o}, 32'd0);

      // Flush at cycle 10 of a DIV.
      @(negedge clk);
      instr_i = FU_DIV;
      a_i = 32'd100;
      b_i = 32'd3;
      valid_a_i = 1'b1;
      valid_b_i = 1'b1;
      @(negedge clk);
      valid_a_i = 1'b0;
      valid_b_i = 1'b0;
      repeat (8) @(negedge clk);
      check("flush busy ready_o", {31'b0, ready_o}, 32'd0);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      check("flush ready_o", {31'b0, ready_o}, 32'd1);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (valid_o) seen++;
         @(negedge clk);
      end
      check("flush no result", 32'(seen), 32'd0);
      do_op(4'd1, 32'd5, 32'd9, 32'hFFFF_FFFC, 1, "SUB after flush");

      // Reset mid-DIV behaves like flush and also clears res_o.
      @(negedge clk);
      instr_i = FU_DIV;
      a_i = 32'd50;
      b_i = 32'd5;
      valid_a_i = 1'b1;
      valid_b_i = 1'b1;
      @(negedge clk);
      idle_inputs();
      repeat (5) @(negedge clk);
      rst_n_i = 1'b0;
      @(negedge clk);
      rst_n_i = 1'b1;
      check("rst mid-DIV res_o", res_o, 32'd0);
      check("rst mid-DIV ready_o", {31'b0, ready_o}, 32'd1);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (valid_o) seen++;
         @(negedge clk);
      end
      check("rst mid-DIV no result", 32'(seen), 32'd0);

      // MUL_LAT=1 instance: result one cycle after accept, MUL_LAT=2 one cycle later.
      @(negedge clk);
      flush_i = 1'b1;
      @(negedge clk);
      flush_i = 1'b0;
      instr_i = FU_MUL;
      a_i = 32'hFFFF_FFFD;
      b_i = 32'd5;
      valid_a_i = 1'b1;
      valid_b_i = 1'b1;
      @(negedge clk);
      valid_a_i = 1'b0;
      valid_b_i = 1'b0;
      check("MUL lat1 valid", {31'b0, valid1}, 32'd1);
      check("MUL lat1 res", res1, 32'hFFFF_FFF1);
      check("MUL lat2 not yet", {31'b0, valid_o}, 32'd0);
      @(negedge clk);
      check("MUL lat2 valid", {31'b0, valid_o}, 32'd1);
      check("MUL lat2 res", res_o, 32'hFFFF_FFF1);

      // Randomized ops against the reference model.
      pick[0] = 32'h0;
      pick[1] = 32'h1;
      pick[2] = 32'hFFFF_FFFF;
      pick[3] = 32'h8000_0000;
      pick[4] = 32'h7FFF_FFFF;
      for (int i = 0; i < 60; i++) begin
         rop = 4'($urandom_range(0, 12));
         if (rop == 4'd12) rop = 4'd15;
         pick[5] = $urandom;
         ra = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 1) == 0 && (rop == 4'd10 || rop == 4'd11)) rb = rb >> 20;
         do_op(rop, ra, rb, model(rop, ra, rb), model_lat(rop), "random");
      end

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
